reg_mem: RTL and testbench

- Single-port, synchronous-write, synchronous-read register memory of 2**ADDR_BITS words, each DATA_WIDTH bits wide.
- A general-purpose scratch or lookup store in the datapath, written and read by one controller on one clock.
- Each entry carries a valid bit, so reads of entries never written since reset return zero.

---
 rtl/reg_mem.sv | 104 ++++++++++
 tb/tb_reg_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem.sv
// reg_mem: single-port register memory, 2**ADDR_BITS words of DATA_WIDTH bits.
// A write stores the word and also passes it straight to data_out
// (write-first). A read returns the stored word after one clock.
// Every entry has a valid bit. Entries not written since reset read as zero.
//
// Ports (positional order is fixed):
//   addr       in   ADDR_BITS   word address for both read and write
//   data_in    in   DATA_WIDTH  write data
//   wen        in   1           write enable, active high
//   clk        in   1           clock, rising edge
//   data_out   out  DATA_WIDTH  registered read data
//   rst_n      in   1           synchronous active-low reset
//   parity_err out  1           only with REG_MEM_PARITY_EN: registered
//                               parity mismatch for a read of a valid entry
//
// Optional feature macro: REG_MEM_PARITY_EN (adds per-entry even parity).

module reg_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 12
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst_n
`ifdef REG_MEM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // The storage array has no reset. The valid bits hide stale contents.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_ff @(posedge clk) begin
    if (rst_n && wen) begin
      mem_q[addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wen) begin
      valid_q[addr] <= 1'b1;
    end
  end

  always_comb begin
    data_out_d = '0;
    if (wen) begin
      data_out_d = data_in;
    end else if (valid_q[addr]) begin
      data_out_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef REG_MEM_PARITY_EN
  logic par_q [DEPTH];
  logic parity_err_q, parity_err_d;

  always_ff @(posedge clk) begin
    if (rst_n && wen) begin
      par_q[addr] <= ^data_in;
    end
  end

  // A mismatch is reported only when a valid entry is read.
  // Writes and reads of invalid entries always report 0.
  always_comb begin
    parity_err_d = 1'b0;
    if (!wen && valid_q[addr]) begin
      parity_err_d = (^mem_q[addr]) != par_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_reg_mem.sv
module tb_reg_mem;

  logic [11:0] addr;
  logic [7:0]  data_in;
  logic        wen;
  logic        clk;
  logic [7:0]  data_out;
  logic        rst_n;
`ifdef REG_MEM_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the contents of each address, plus whether it has been written.
  logic [7:0] model_mem   [4096];
  bit         model_valid [4096];

  reg_mem #(.DATA_WIDTH(8), .ADDR_BITS(12)) dut (
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .clk      (clk),
    .data_out (data_out),
    .rst_n    (rst_n)
`ifdef REG_MEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock cycle and return the value the model expects on data_out afterwards.
  task automatic step(input logic [11:0] a, input logic [7:0] d, input logic w,
                      input logic r, output logic [7:0] exp);
    @(negedge clk);
    addr = a; data_in = d; wen = w; rst_n = r;
    @(posedge clk);
    #1;
    if (!r) begin
      exp = 8'h00;
      for (int i = 0; i < 4096; i++) model_valid[i] = 1'b0;
    end else if (w) begin
      model_mem[a]   = d;
      model_valid[a] = 1'b1;
      exp = d;
    end else begin
      exp = model_valid[a] ? model_mem[a] : 8'h00;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    step(12'd0, 8'h00, 1'b0, 1'b0, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_out got=%h want=%h", data_out, 8'h00);
    end
`ifdef REG_MEM_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity_err got=%b want=0", parity_err);
    end
`endif
  endtask

  task automatic test_seq_write_read();
    logic [7:0] exp;
    for (int i = 1; i <= 32; i++) begin
      step(12'(i), 8'(i), 1'b1, 1'b1, exp);
      checks++;
      if (data_out !== 8'(i)) begin
        errors++;
        $display("FAIL seq_write_through addr=%0d got=%h want=%h", i, data_out, 8'(i));
      end
    end
    for (int i = 1; i <= 32; i++) begin
      step(12'(i), 8'hC3, 1'b0, 1'b1, exp);
      checks++;
      if (data_out !== 8'(i)) begin
        errors++;
        $display("FAIL seq_readback addr=%0d got=%h want=%h", i, data_out, 8'(i));
      end
    end
  endtask

  task automatic test_unwritten();
    logic [7:0] exp;
    step(12'd0, 8'h5A, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL unwritten_addr0 got=%h want=00", data_out);
    end
    step(12'd4095, 8'h5A, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL unwritten_addr4095 got=%h want=00", data_out);
    end
  endtask

  task automatic test_write_through();
    logic [7:0] exp;
    step(12'd100, 8'hA5, 1'b1, 1'b1, exp);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL write_through got=%h want=a5", data_out);
    end
    step(12'd100, 8'h00, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL write_then_read got=%h want=a5", data_out);
    end
  endtask

  task automatic test_reset_clears();
    logic [7:0] exp;
    step(12'd7, 8'h3C, 1'b1, 1'b1, exp);
    step(12'd7, 8'hFF, 1'b1, 1'b0, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_over_write got=%h want=00", data_out);
    end
    step(12'd7, 8'h00, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_cleared_valid got=%h want=00", data_out);
    end
    step(12'd5, 8'h00, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_cleared_addr5 got=%h want=00", data_out);
    end
  endtask

  task automatic test_overwrite_extremes();
    logic [7:0] exp;
    step(12'd4095, 8'h11, 1'b1, 1'b1, exp);
    step(12'd4095, 8'hEE, 1'b1, 1'b1, exp);
    step(12'd0,    8'h00, 1'b1, 1'b1, exp);
    step(12'd4095, 8'h00, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'hEE) begin
      errors++;
      $display("FAIL overwrite_4095 got=%h want=ee", data_out);
    end
    step(12'd0, 8'h77, 1'b0, 1'b1, exp);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL addr0_zero got=%h want=00", data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic [7:0] d;
    logic [11:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 12'($urandom_range(0, 4095));
      d = 8'($urandom_range(0, 255));
      step(a, d, 1'b1, 1'b1, exp);
      checks++;
      if (data_out !== d) begin
        errors++;
        $display("FAIL b2b_write addr=%0d got=%h want=%h", a, data_out, d);
      end
      step(a, ~d, 1'b0, 1'b1, exp);
      checks++;
      if (data_out !== d) begin
        errors++;
        $display("FAIL b2b_read addr=%0d got=%h want=%h", a, data_out, d);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    logic [11:0] a;
    logic [7:0] d;
    logic w, r;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 31));
      d = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 79) != 0);
      step(a, d, w, r, exp);
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL random op=%0d addr=%0d wen=%b rst_n=%b got=%h want=%h",
                 i, a, w, r, data_out, exp);
      end
`ifdef REG_MEM_PARITY_EN
      checks++;
      if (parity_err !== 1'b0) begin
        errors++;
        $display("FAIL random_parity op=%0d got=%b want=0", i, parity_err);
      end
`endif
    end
  endtask

`ifdef REG_MEM_PARITY_EN
  task automatic test_parity();
    logic [7:0] exp;
    step(12'd9, 8'h0F, 1'b1, 1'b1, exp);
    step(12'd200, 8'h3A, 1'b1, 1'b1, exp);
    @(negedge clk);
    dut.mem_q[9] = dut.mem_q[9] ^ 8'h01;
    step(12'd9, 8'h00, 1'b0, 1'b1, exp);
    checks++;
    if (parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_flip got=%b want=1", parity_err);
    end
    step(12'd200, 8'h00, 1'b0, 1'b1, exp);
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clean got=%b want=0", parity_err);
    end
  endtask
`endif

  initial begin
    addr = '0; data_in = '0; wen = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      model_mem[i]   = 8'h00;
      model_valid[i] = 1'b0;
    end
    test_reset();
    test_seq_write_read();
    test_unwritten();
    test_write_through();
    test_reset_clears();
    test_overwrite_extremes();
    test_back_to_back();
    test_random();
`ifdef REG_MEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
